hier_node_dispatch: RTL and testbench

Parametrised hierarchy node that owns NUM_CHILDREN leaf instances, generated rather than hand-listed. It dispatches incoming work tokens round-robin to idle leaves, each leaf processes its token for a fixed latency, and a round-robin collector returns results on a tagged output stream. The block sits between a parent node and its leaf tier in generated module trees, and is the standard node type at every hierarchy level.

---
 rtl/hier_node_dispatch_pkg.sv | 23 ++
 rtl/hier_node_dispatch_if.sv | 34 +++
 rtl/hier_node_dispatch_leaf.sv | 79 +++++++
 rtl/hier_node_dispatch.sv | 138 +++++++++++++
 tb/tb_hier_node_dispatch.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hier_node_dispatch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : hier_node_pkg                                                 |
// | Purpose    : Shared types and helpers for the hierarchy dispatch node.     |
// |              leaf_state_e - per-leaf state (IDLE/RUN/DONE)                 |
// |              child_id_w   - width of a child index (never below 1 bit)     |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package hier_node_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } leaf_state_e;

  // A single-child node still needs a 1-bit id port.
  function automatic int child_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hier_node_dispatch_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface  : hier_node_dispatch_if                                         |
// | Purpose    : Token input stream, tagged result output stream and busy.     |
// |   in_valid/in_ready/in_data             - work token handshake            |
// |   out_valid/out_ready/out_data/out_child_id - result handshake + leaf tag  |
// |   busy                                  - node has work in flight          |
// |   modport slave  : the node side; modport master : the parent side        |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface hier_node_dispatch_if #(
  parameter int DATA_W = 16,
  parameter int ID_W   = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ID_W-1:0]   out_child_id;
  logic              busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_child_id, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_child_id, busy
  );
endinterface
`default_nettype wire

// File: rtl/hier_node_dispatch_leaf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : hier_leaf                                                     |
// | Purpose    : One leaf worker. Accepts a token while IDLE, runs for         |
// |              LEAF_LAT cycles in total, then holds its result in DONE until |
// |              the collector takes it.                                       |
// |   clk, rst_n   - clock, asynchronous active-low reset                      |
// |   dispatch     - load data and start (only asserted while idle)           |
// |   collect      - result taken (only asserted while done)                  |
// |   data         - token payload                                             |
// |   idle, done   - state flags                                               |
// |   result       - data + CHILD_IDX, wrapping modulo 2^DATA_W                |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module hier_leaf
  import hier_node_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int LEAF_LAT  = 4,
  parameter int CHILD_IDX = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dispatch,
  input  logic              collect,
  input  logic [DATA_W-1:0] data,
  output logic              idle,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int                CNT_W  = (LEAF_LAT > 1) ? $clog2(LEAF_LAT) : 1;
  localparam logic [CNT_W-1:0]  c_LAST = CNT_W'(LEAF_LAT - 1);
  localparam logic [DATA_W-1:0] c_IDX  = DATA_W'(CHILD_IDX);

  leaf_state_e       r_state;
  leaf_state_e       w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_result;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state. The dispatch edge counts as the first latency cycle, so a
  // one-cycle leaf skips RUN and is DONE straight after dispatch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (dispatch) w_state_nxt = (c_LAST == '0) ? DONE : RUN;
      RUN:     if (r_cnt == c_LAST) w_state_nxt = DONE;
      DONE:    if (collect) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    idle   = (r_state == IDLE);
    done   = (r_state == DONE);
    result = r_result;
  end

  // Latency counter: 1 on the first RUN cycle, counts up to LEAF_LAT-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_cnt <= '0;
    else if (w_state_nxt == RUN)    r_cnt <= (r_state == RUN) ? r_cnt + 1'b1 : CNT_W'(1);
    else                            r_cnt <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_result <= '0;
    else if (r_state == IDLE && dispatch) r_result <= data + c_IDX;
  end

endmodule
`default_nettype wire

// File: rtl/hier_node_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : hier_node_dispatch                                            |
// | Purpose    : Hierarchy node owning NUM_CHILDREN generated leaves. Tokens   |
// |              are dispatched round-robin to idle leaves; finished results   |
// |              are collected round-robin into a registered, id-tagged output.|
// |   clk, rst_n   - clock, asynchronous active-low reset                      |
// |   bus (slave)  - in_*/out_* handshakes, out_child_id, busy                 |
// |   perf_accepted/perf_returned/perf_stall - 32-bit wrapping counters,       |
// |                  present only when HIER_NODE_DISPATCH_PERF_EN is defined    |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module hier_node_dispatch
  import hier_node_pkg::*;
#(
  parameter int NUM_CHILDREN = 5,
  parameter int DATA_W       = 16,
  parameter int LEAF_LAT     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hier_node_dispatch_if.slave  bus
`ifdef HIER_NODE_DISPATCH_PERF_EN
  ,
  output logic [31:0]          perf_accepted,
  output logic [31:0]          perf_returned,
  output logic [31:0]          perf_stall
`endif
);

  localparam int ID_W = child_id_w(NUM_CHILDREN);

  logic [NUM_CHILDREN-1:0] w_idle;
  logic [NUM_CHILDREN-1:0] w_done;
  logic [NUM_CHILDREN-1:0] w_disp;
  logic [NUM_CHILDREN-1:0] w_coll;
  logic [DATA_W-1:0]       w_res [NUM_CHILDREN];

  logic [ID_W-1:0]   r_dptr, r_cptr, r_out_id;
  logic [ID_W-1:0]   w_dsel, w_csel;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              w_any_idle, w_in_fire, w_take, w_coll_fire;

  // First requester at or after ptr, cyclically. Iterating from the far end
  // lets the nearest candidate overwrite the others without a break.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_CHILDREN-1:0] req,
                                               input logic [ID_W-1:0]         ptr);
    int              idx;
    logic [ID_W-1:0] sel;
    rr_pick = ptr;
    for (int k = NUM_CHILDREN - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CHILDREN) idx = idx - NUM_CHILDREN;
      sel = ID_W'(idx);
      if (req[sel]) rr_pick = sel;
    end
  endfunction

  function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] idx);
    return (idx == ID_W'(NUM_CHILDREN - 1)) ? '0 : idx + 1'b1;
  endfunction

  for (genvar g = 0; g < NUM_CHILDREN; g++) begin : g_leaf
    hier_leaf #(
      .DATA_W    (DATA_W),
      .LEAF_LAT  (LEAF_LAT),
      .CHILD_IDX (g)
    ) u_leaf (
      .clk      (clk),
      .rst_n    (rst_n),
      .dispatch (w_disp[g]),
      .collect  (w_coll[g]),
      .data     (bus.in_data),
      .idle     (w_idle[g]),
      .done     (w_done[g]),
      .result   (w_res[g])
    );
  end

  assign w_any_idle  = |w_idle;
  assign w_in_fire   = bus.in_valid && w_any_idle;
  // Output register can accept a new result when empty or draining now.
  assign w_take      = !r_out_valid || bus.out_ready;
  assign w_coll_fire = w_take && (|w_done);
  assign w_dsel      = rr_pick(w_idle, r_dptr);
  assign w_csel      = rr_pick(w_done, r_cptr);

  // Dispatch hits an IDLE leaf and collect a DONE leaf, so they never collide.
  always_comb begin
    w_disp = '0;
    w_coll = '0;
    if (w_in_fire)   w_disp[w_dsel] = 1'b1;
    if (w_coll_fire) w_coll[w_csel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dptr      <= '0;
      r_cptr      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
    end else begin
      if (w_in_fire) r_dptr <= ptr_inc(w_dsel);
      if (w_coll_fire) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_res[w_csel];
        r_out_id    <= w_csel;
        r_cptr      <= ptr_inc(w_csel);
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready     = w_any_idle;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_data     = r_out_data;
  assign bus.out_child_id = r_out_id;
  assign bus.busy         = !(&w_idle) || r_out_valid;

`ifdef HIER_NODE_DISPATCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_accepted <= '0;
      perf_returned <= '0;
      perf_stall    <= '0;
    end else begin
      if (w_in_fire)                      perf_accepted <= perf_accepted + 1'b1;
      if (r_out_valid && bus.out_ready)   perf_returned <= perf_returned + 1'b1;
      if (bus.in_valid && !w_any_idle)    perf_stall    <= perf_stall + 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hier_node_dispatch.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_hier_node_dispatch                                         |
// | Purpose    : Bench for hier_node_dispatch (5 children / 16 bit / latency 4 |
// |              with a timestamped leaf-pool reference model and a result     |
// |              scoreboard, plus a 1-child / latency-1 instance).             |
// |              Perf ports connected when HIER_NODE_DISPATCH_PERF_EN defined. |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_hier_node_dispatch;
  import hier_node_pkg::*;

  localparam int N   = 5;
  localparam int W   = 16;
  localparam int L   = 4;
  localparam int IDW = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hier_node_dispatch_if #(.DATA_W(W), .ID_W(IDW)) bus  ();
  hier_node_dispatch_if #(.DATA_W(W), .ID_W(1))   bus1 ();

`ifdef HIER_NODE_DISPATCH_PERF_EN
  logic [31:0] pa, pr, ps, pa1, pr1, ps1;
`endif

  hier_node_dispatch #(.NUM_CHILDREN(N), .DATA_W(W), .LEAF_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef HIER_NODE_DISPATCH_PERF_EN
    , .perf_accepted(pa), .perf_returned(pr), .perf_stall(ps)
`endif
  );

  hier_node_dispatch #(.NUM_CHILDREN(1), .DATA_W(W), .LEAF_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
`ifdef HIER_NODE_DISPATCH_PERF_EN
    , .perf_accepted(pa1), .perf_returned(pr1), .perf_stall(ps1)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: pool of leaves with ready times -------
  typedef struct {
    int          id;
    logic [W-1:0] data;
  } exp_t;

  exp_t         exp_q[$];
  bit           m_pend [N];   // leaf holds a token (running or finished)
  int           m_ready[N];   // first cycle the leaf's result is available
  logic [W-1:0] m_res  [N];
  int           m_dptr, m_cptr, cyc;
  bit           m_ov;
  int           m_acc, m_ret, m_stall;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 1'b0; m_ready[i] = 0; m_res[i] = '0;
    end
    m_dptr = 0; m_cptr = 0; m_ov = 1'b0; cyc = 0;
    m_acc = 0; m_ret = 0; m_stall = 0;
    exp_q.delete();
  endtask

  // Advance the model across the next clock edge (cycle cyc -> cyc+1).
  task automatic model_step(input bit iv, input logic [W-1:0] idata, input bit ordy);
    int   e, d, c, i;
    exp_t ex;
    e = cyc + 1;
    d = -1;
    c = -1;
    for (int k = 0; k < N; k++) begin
      i = (m_dptr + k) % N;
      if (d < 0 && !m_pend[i]) d = i;
    end
    if (iv && d < 0) m_stall++;
    if (!iv) d = -1;
    if (!m_ov || ordy) begin
      for (int k = 0; k < N; k++) begin
        i = (m_cptr + k) % N;
        if (c < 0 && m_pend[i] && m_ready[i] <= cyc) c = i;
      end
    end
    if (c >= 0) begin
      ex.id = c; ex.data = m_res[c];
      exp_q.push_back(ex);
      m_pend[c] = 1'b0;
      m_cptr = (c + 1) % N;
      m_ov = 1'b1;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    if (d >= 0) begin
      // Result ready LEAF_LAT-1 cycles after the accepting edge.
      m_pend[d]  = 1'b1;
      m_ready[d] = e + L - 1;
      m_res[d]   = idata + W'(d);
      m_dptr     = (d + 1) % N;
      m_acc++;
    end
    cyc = e;
  endtask

  task automatic check_state();
    bit any_free, any_pend;
    any_free = 1'b0; any_pend = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (m_pend[i]) any_pend = 1'b1;
      else           any_free = 1'b1;
    end
    check("in_ready",  32'(bus.in_ready),  32'(any_free));
    check("out_valid", 32'(bus.out_valid), 32'(m_ov));
    check("busy",      32'(bus.busy),      32'(any_pend || m_ov));
  endtask

  // One cycle of stimulus, called at posedge+1.
  task automatic drive_one(input bit iv, input logic [W-1:0] dat, input bit ordy);
    check_state();
    bus.in_valid  = iv;
    bus.in_data   = dat;
    bus.out_ready = ordy;
    model_step(iv, dat, ordy);
    @(posedge clk); #1;
  endtask

  task automatic drive_rand(input int p_in, input int p_rdy, input int p_ff);
    logic [W-1:0] dat;
    dat = W'($urandom);
    if ($urandom_range(99) < p_ff) dat = 16'hFFFF - W'($urandom_range(2));
    drive_one($urandom_range(99) < p_in, dat, $urandom_range(99) < p_rdy);
  endtask

  task automatic do_reset(input int hold);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_async_in_ready",  32'(bus.in_ready),  32'd1);
    repeat (hold) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    model_step(1'b0, '0, 1'b0);
    check("rst_out_data", 32'(bus.out_data),     32'd0);
    check("rst_out_id",   32'(bus.out_child_id), 32'd0);
    check_state();
  endtask

  // ---------------- scoreboard monitor ------------------------------------
  always @(negedge clk) begin : monitor
    exp_t ex;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_result", 32'(bus.out_child_id), 32'hFFFF_FFFF);
      end else begin
        ex = exp_q.pop_front();
        check("sb_child_id", 32'(bus.out_child_id), 32'(ex.id));
        check("sb_data",     32'(bus.out_data),     32'(ex.data));
        m_ret++;
      end
    end
  end

  // ---------------- stimulus ----------------------------------------------
  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
    @(posedge clk); #1;
    do_reset(3);

    // Single token 0x0010 -> child 0, result 0x0010 four edges later.
    drive_one(1'b1, 16'h0010, 1'b1);
    repeat (8) drive_one(1'b0, '0, 1'b1);

    // Reset while leaves are running: in-flight tokens must vanish.
    for (int i = 0; i < 3; i++) drive_one(1'b1, W'(16'h100 + i), 1'b1);
    drive_one(1'b0, '0, 1'b1);
    do_reset(2);
    repeat (8) drive_one(1'b0, '0, 1'b1);

    // Back-to-back tokens 0..5: ids 0..4 data 0,2,4,6,8, sixth waits.
    for (int i = 0; i < 6; i++) drive_one(1'b1, W'(i), 1'b1);
    repeat (10) drive_one(1'b0, '0, 1'b1);

    // Wrap: 0xFFFF on child 3 gives 0x0002.
    do_reset(1);
    for (int i = 0; i < 3; i++) drive_one(1'b1, 16'h0040, 1'b1);
    drive_one(1'b1, 16'hFFFF, 1'b1);
    repeat (10) drive_one(1'b0, '0, 1'b1);

    // Backpressure: fill every leaf, hold output for 20+ cycles, then drain.
    repeat (25) drive_rand(100, 0, 20);
    repeat (15) drive_one(1'b0, '0, 1'b1);

    // Randomised traffic in mixed load/backpressure regimes.
    for (int blk = 0; blk < 30; blk++) begin
      int p_in, p_rdy;
      p_in  = $urandom_range(100);
      p_rdy = $urandom_range(100);
      repeat (100) drive_rand(p_in, p_rdy, 10);
    end

    repeat (30) drive_one(1'b0, '0, 1'b1);
    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    check("idle_at_end", 32'(bus.busy), 32'd0);
`ifdef HIER_NODE_DISPATCH_PERF_EN
    check("perf_accepted", pa, 32'(m_acc));
    check("perf_returned", pr, 32'(m_ret));
    check("perf_stall",    ps, 32'(m_stall));
`endif

    // ---------- single child, latency 1 ----------
    bus1.in_valid = 1'b1; bus1.in_data = 16'h1234; bus1.out_ready = 1'b0;
    check("n1_in_ready_idle", 32'(bus1.in_ready), 32'd1);
    @(posedge clk); #1;                       // accepted
    bus1.in_valid = 1'b0;
    check("n1_in_ready_t1",  32'(bus1.in_ready),  32'd0);
    check("n1_out_valid_t1", 32'(bus1.out_valid), 32'd0);
    check("n1_busy_t1",      32'(bus1.busy),      32'd1);
    @(posedge clk); #1;
    check("n1_out_valid_t2", 32'(bus1.out_valid),    32'd1);
    check("n1_out_data_t2",  32'(bus1.out_data),     32'h1234);
    check("n1_out_id_t2",    32'(bus1.out_child_id), 32'd0);
    check("n1_in_ready_t2",  32'(bus1.in_ready),     32'd1);
    bus1.in_valid = 1'b1; bus1.in_data = 16'h0001;
    @(posedge clk); #1;                       // second token accepted, output stalled
    bus1.in_valid = 1'b0;
    @(posedge clk); #1;
    check("n1_stall_in_ready", 32'(bus1.in_ready), 32'd0);
    check("n1_stall_data",     32'(bus1.out_data), 32'h1234);
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    check("n1_next_valid", 32'(bus1.out_valid), 32'd1);
    check("n1_next_data",  32'(bus1.out_data),  32'h0001);
    @(posedge clk); #1;
    check("n1_drained_valid", 32'(bus1.out_valid), 32'd0);
    check("n1_drained_busy",  32'(bus1.busy),      32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
